// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: wash-cycle sequencer (coin credit, program modes, fill/heat, timed phases, lid pause, cancel-to-drain) driving valve/heater/motor indicators
module wm_cycle_controller #(
  parameter int COINS_REQUIRED = 2,
  parameter int CREDIT_W       = 3,
  parameter int TIMER_W        = 16,
  parameter int SOAK_CYCLES    = 1000,
  parameter int WASH_CYCLES    = 2000,
  parameter int RINSE_CYCLES   = 1000,
  parameter int SPIN_CYCLES    = 500
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                lid,
  input  logic                coin,
  input  logic                cancel,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                fill_Water,
  input  logic                heat_Water,
  output logic                idle,
  output logic                ready,
  output logic                soak_Operation,
  output logic                wash_Operation,
  output logic                rinse_Operation,
  output logic                spin_Operation,
  output logic                water_Intake,
  output logic                heater_On,
  output logic                coin_Return,
  output logic                paused,
  output logic                done,
  output logic [CREDIT_W-1:0] credit
);
  typedef enum logic [3:0] {
    S_IDLE, S_READY, S_FILL, S_HEAT, S_SOAK, S_WASH, S_RINSE, S_SPIN, S_DONE
  } state_t;
  localparam logic [TIMER_W-1:0]  SOAK_LD    = TIMER_W'(SOAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  WASH_LD    = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  RINSE_LD   = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  SPIN_LD    = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(COINS_REQUIRED);
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [1:0]          mode_q, mode_d;
  logic                pass_q, pass_d;
  logic                paused_q, paused_d;
  logic                ret_q, ret_d;
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    mode_d   = mode_q;
    pass_d   = pass_q;
    paused_d = 1'b0;
    ret_d    = coin && state_q != S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (cancel && credit_q != '0) begin
          ret_d    = 1'b1;
          credit_d = '0;
        end else if (coin) begin
          credit_d = (credit_q + CREDIT_W'(1) >= CREDIT_MAX) ? CREDIT_MAX : credit_q + CREDIT_W'(1);
          state_d  = (credit_d == CREDIT_MAX) ? S_READY : S_IDLE;
        end
      end
      S_READY: begin
        if (cancel) begin
          ret_d    = 1'b1;
          credit_d = '0;
          state_d  = S_IDLE;
        end else if (start && !lid) begin
          mode_d   = mode;
          credit_d = '0;
          state_d  = S_FILL;
        end
      end
      S_DONE: state_d = lid ? S_IDLE : S_DONE;
      default: begin
        // cancel outranks the lid freeze so a lid-open cancel still heads to drain, just paused
        if (cancel && state_q != S_SPIN) begin
          state_d  = S_SPIN;
          paused_d = lid;
        end else if (lid) paused_d = 1'b1;
        else if (state_q == S_FILL) state_d = !fill_Water ? S_FILL : (mode_q == 2'd1) ? S_WASH : (mode_q == 2'd3) ? S_RINSE : S_HEAT;
        else if (state_q == S_HEAT) state_d = heat_Water ? S_SOAK : S_HEAT;
        else if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
        else if (state_q == S_RINSE && mode_q == 2'd2 && !pass_q) begin
          pass_d  = 1'b1;
          timer_d = RINSE_LD;
        end else state_d = (state_q == S_SOAK) ? S_WASH : (state_q == S_WASH) ? S_RINSE : (state_q == S_RINSE) ? S_SPIN : S_DONE;
      end
    endcase
    if (state_d != state_q) begin
      timer_d = (state_d == S_SOAK) ? SOAK_LD : (state_d == S_WASH) ? WASH_LD : (state_d == S_RINSE) ? RINSE_LD : (state_d == S_SPIN) ? SPIN_LD : '0;
      pass_d  = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      timer_q  <= '0;
      mode_q   <= '0;
      pass_q   <= 1'b0;
      paused_q <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
      mode_q   <= mode_d;
      pass_q   <= pass_d;
      paused_q <= paused_d;
      ret_q    <= ret_d;
    end
  end
  assign idle            = state_q == S_IDLE;
  assign ready           = state_q == S_READY;
  assign done            = state_q == S_DONE;
  assign soak_Operation  = state_q == S_SOAK && !paused_q;
  assign wash_Operation  = state_q == S_WASH && !paused_q;
  assign rinse_Operation = state_q == S_RINSE && !paused_q;
  assign spin_Operation  = state_q == S_SPIN && !paused_q;
  assign water_Intake    = state_q == S_FILL && !paused_q;
  assign heater_On       = state_q == S_HEAT && !paused_q;
  assign paused          = paused_q;
  assign coin_Return     = ret_q;
  assign credit          = credit_q;
endmodule
